// File: rtl/seq_driven_skid_pipe_if.sv
// Handshake bundle for the two-entry skid pipeline: upstream valid/ready/data,
// downstream valid/ready/data, the transfer counter and the single-bit fixture feed.
interface seq_driven_skid_pipe_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [COUNT_W-1:0] xfer_count;
  logic               data_out;

  // Producer/consumer side that talks to the pipe.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  xfer_count,
    input  data_out
  );

  // The pipe itself.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output xfer_count,
    output data_out
  );
endinterface

// File: rtl/seq_driven_skid_pipe.sv
// Two-entry skid-buffer pipeline stage (main + skid register) with registered handshakes
// on both sides and a wrapping count of completed output transfers.
module seq_driven_skid_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  seq_driven_skid_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic [COUNT_W-1:0] count_q;

  logic in_ready;
  logic out_valid;
  logic in_acc;
  logic out_acc;

  // Handshake outputs come from the registered state only; the illegal encoding
  // reads like StEmpty until the next edge clears it.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q == StBusy) || (state_q == StFull);

  assign in_acc  = bus.in_valid & in_ready;
  assign out_acc = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (in_acc) begin
          main_d  = bus.in_data;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (in_acc && out_acc) begin
          main_d = bus.in_data;
        end else if (in_acc) begin
          skid_d  = bus.in_data;
          state_d = StFull;
        end else if (out_acc) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_acc) begin
          main_d  = skid_q;
          state_d = StBusy;
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (out_acc) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = main_q;
  assign bus.xfer_count = count_q;
  assign bus.data_out   = out_valid & main_q[0];

endmodule

// File: tb/tb_seq_driven_skid_pipe.sv
// Directed plus randomized bench for seq_driven_skid_pipe, checked against a
// two-deep FIFO reference model held in a queue.
module tb_seq_driven_skid_pipe;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned COUNT_W = 4;

  logic clk;
  logic rst;

  seq_driven_skid_pipe_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();

  seq_driven_skid_pipe #(
    .WIDTH   (WIDTH),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: items held in arrival order, plus output transfer count.
  logic [WIDTH-1:0] model_q[$];
  int               model_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic exp_valid;
    exp_valid = (model_q.size() > 0);
    check("in_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));
    check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    check("xfer_count", 32'(bus.xfer_count), 32'(model_cnt % (1 << COUNT_W)));
    if (exp_valid) begin
      check("out_data", 32'(bus.out_data), 32'(model_q[0]));
      check("data_out", 32'(bus.data_out), 32'(model_q[0][0]));
    end else begin
      check("data_out_idle", 32'(bus.data_out), 32'd0);
    end
  endtask

  // One clock cycle: drive inputs, check registered outputs, advance edge, update model.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
    logic take_in;
    logic take_out;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    check_outputs();
    take_in  = v && (model_q.size() < 2);
    take_out = r && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (take_out) begin
      void'(model_q.pop_front());
      model_cnt++;
    end
    if (take_in) model_q.push_back(d);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    model_cnt = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_xfer_count", 32'(bus.xfer_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single item held under backpressure, then drained.
    step(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("single_xfer_count", 32'(bus.xfer_count), 32'd1);

    // Skid fill, rejected offer while full, ordered drain.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    step(1'b1, 8'h03, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("drain1_in_ready", 32'(bus.in_ready), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Reset asserted mid-cycle while FULL with 0x11/0x22.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    check("midrst_xfer_count", 32'(bus.xfer_count), 32'd0);
    check("midrst_data_out", 32'(bus.data_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #1;
    step(1'b1, 8'h33, 1'b0);
    check("post_rst_first", 32'(bus.out_data), 32'h33);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Streaming 20 items back-to-back from a zeroed counter.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_cnt = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("stream_wrap_count", 32'(bus.xfer_count), 32'd4);

    // Random valid/ready stalls against the model.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    check("final_empty", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_driven_skid_pipe.md
Name: seq_driven_skid_pipe

Overview:
- Fully driven two-entry skid-buffer pipeline stage with valid/ready handshakes on both sides and a wrapping transfer counter.
- Sits directly upstream of the undriven-signal fixture, whose consumer input is `data_out`. Every signal it declares has at least one sequential or continuous driver and at least one reader.
- The unused/undriven analysis must report zero findings on this block. Simulation must prove the handshake behaviour below.

Parameters:
- WIDTH, 8: data width of in_data, out_data and both storage registers.
- COUNT_W, 4: width of xfer_count; wraps modulo 2^COUNT_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers in_data this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid item.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  head-of-pipe payload.
- xfer_count  output  COUNT_W  number of completed output handshakes, modulo 2^COUNT_W.
- data_out  output  1  equals out_data[0] while out_valid=1, else 0; feeds the downstream fixture.

Behaviour:
- Handshake definitions:
  - in_acc = in_valid & in_ready.
  - out_acc = out_valid & out_ready.
- Storage is a main register plus a skid register, each WIDTH bits.
- State machine, encoded as 2 bits (EMPTY, BUSY, FULL); the encoding value 3 is illegal and recovers to EMPTY.
  - EMPTY: in_ready=1, out_valid=0.
    - in_acc: main<=in_data, go to BUSY.
    - Otherwise: hold.
  - BUSY: in_ready=1, out_valid=1, out_data=main.
    - in_acc & out_acc: main<=in_data, stay in BUSY.
    - in_acc only: skid<=in_data, go to FULL.
    - out_acc only: go to EMPTY.
    - Neither: hold.
  - FULL: in_ready=0, out_valid=1, out_data=main.
    - out_acc: main<=skid, go to BUSY.
    - in_valid is ignored; no data is lost.
- in_ready and out_valid are decoded from the registered state only. Neither has a combinational path from in_valid or out_ready.
- Latency: an item accepted at edge N is presented on out_data with out_valid=1 after edge N (one cycle).
- Ordering: strict FIFO; skid data always leaves after main data.
- Throughput: 1 item/cycle sustained in BUSY with both sides active.
- out_data and out_valid must remain stable while out_valid=1 and out_ready=0.
- xfer_count increments by 1 on every out_acc, wrapping from 2^COUNT_W-1 to 0.
- Reset (async assert; release synchronous to clk):
  - State goes to EMPTY; main, skid and xfer_count go to 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, data_out=0, xfer_count=0.
  - A reset mid-operation discards all stored items, including in FULL.
- The illegal state behaves as EMPTY's outputs for one cycle, then the next edge forces EMPTY.
- Lint requirements:
  - No declared signal may lack a driver.
  - No declared signal may lack a reader.
  - No multiply-driven signals.

Test Plan:
- Reset → outputs: assert rst mid-cycle with the block in FULL holding 0x11/0x22 → immediately in_ready=1, out_valid=0, out_data=0, xfer_count=0. After release, the first item 0x33 emerges, not 0x11.
- Single item: in_valid=1, in_data=0xA5 for one cycle with out_ready=0 → next cycle out_valid=1, out_data=0xA5, data_out=1. It holds 0xA5 until out_ready=1, then xfer_count=1.
- Skid fill: out_ready=0; send 0x01 then 0x02 → state FULL, in_ready=0 after the second edge.
  - Offer 0x03 while FULL → not accepted.
  - Raise out_ready → outputs 0x01, 0x02 in order; in_ready returns to 1 after the first drain.
- Streaming: out_ready=1, send 0x00..0x13 back-to-back (20 items) → 20 consecutive output cycles, in order. xfer_count wraps and reads 4 (20 mod 16).
- Random stalls: random in_valid/out_ready over 1000 cycles → scoreboard shows no loss, duplication or reordering. in_ready=0 only in FULL; out_valid=0 only in EMPTY.
- Lint: run the unused/undriven analysis on this block → zero warnings.
